// File: rtl/string_loader.sv
// Host-side loader for the sniffer string-match pattern: assembles a byte stream
// in a shadow buffer and commits it atomically to string_out/strlen_out.
module string_loader #(
  parameter int MAX_LEN = 17,
  parameter int LEN_W   = 5
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [7:0]             wr_byte,
  input  logic                   wr_last,
  input  logic                   abort,
  input  logic                   err_clr,
  output logic [8*MAX_LEN-1:0]   string_out,
  output logic [LEN_W-1:0]       strlen_out,
  output logic                   str_valid,
  output logic                   cmp_clear,
  output logic                   err_overflow,
  output logic                   busy,
  output logic [1:0]             state_dbg
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] MAX_CNT = LEN_W'(MAX_LEN);

  state_t                     state_q, state_d;
  logic [LEN_W-1:0]           count_q, count_d;
  logic [MAX_LEN-1:0][7:0]    shadow_q, shadow_d;
  logic [8*MAX_LEN-1:0]       string_q, string_d;
  logic [LEN_W-1:0]           strlen_q, strlen_d;
  logic                       str_valid_q, str_valid_d;
  logic                       cmp_clear_q, cmp_clear_d;
  logic                       err_q, err_d;
  logic                       xfer;
  logic                       err_set;

  // Handshake: a byte transfers on a rising edge where wr_valid && wr_ready.
  // wr_ready drops only during the single COMMIT cycle; abort never affects it.
  assign wr_ready     = (state_q != COMMIT);
  assign busy         = (state_q != IDLE);
  assign state_dbg    = state_q;
  assign string_out   = string_q;
  assign strlen_out   = strlen_q;
  assign str_valid    = str_valid_q;
  assign cmp_clear    = cmp_clear_q;
  assign err_overflow = err_q;

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shadow_d    = shadow_q;
    string_d    = string_q;
    strlen_d    = strlen_q;
    str_valid_d = str_valid_q;
    cmp_clear_d = 1'b0;
    err_set     = 1'b0;
    xfer        = wr_valid && wr_ready;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          shadow_d[0] = wr_byte;
          count_d     = LEN_W'(1);
          state_d     = wr_last ? COMMIT : LOAD;
        end
      end
      LOAD: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (xfer) begin
          if (count_q < MAX_CNT) begin
            shadow_d[count_q] = wr_byte;
            count_d           = count_q + LEN_W'(1);
            state_d           = wr_last ? COMMIT : LOAD;
          end else if (wr_last) begin
            err_set = 1'b1;
            count_d = '0;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          count_d = '0;
          state_d = IDLE;
        end else if (xfer && wr_last) begin
          err_set = 1'b1;
          count_d = '0;
          state_d = IDLE;
        end
      end
      COMMIT: begin
        // Stale bytes beyond the new length are zeroed so the comparator sees a clean pattern.
        for (int k = 0; k < MAX_LEN; k++) begin
          string_d[8*k +: 8] = (LEN_W'(k) < count_q) ? shadow_q[k] : 8'h00;
        end
        strlen_d    = count_q - LEN_W'(1);
        str_valid_d = 1'b1;
        cmp_clear_d = 1'b1;
        count_d     = '0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (err_set)      err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
    else              err_d = err_q;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shadow_q    <= '0;
      string_q    <= '0;
      strlen_q    <= '0;
      str_valid_q <= 1'b0;
      cmp_clear_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      shadow_q    <= shadow_d;
      string_q    <= string_d;
      strlen_q    <= strlen_d;
      str_valid_q <= str_valid_d;
      cmp_clear_q <= cmp_clear_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_string_loader.sv
// Directed bench for string_loader: commit latency, masking, overflow/drain,
// abort, async reset mid-load and back-to-back strings under held wr_valid.
module tb_string_loader;

  localparam int MAX_LEN = 17;
  localparam int LEN_W   = 5;
  localparam int SW      = 8 * MAX_LEN;

  logic             clk = 1'b0;
  logic             n_rst;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       wr_byte;
  logic             wr_last;
  logic             abort;
  logic             err_clr;
  logic [SW-1:0]    string_out;
  logic [LEN_W-1:0] strlen_out;
  logic             str_valid;
  logic             cmp_clear;
  logic             err_overflow;
  logic             busy;
  logic [1:0]       state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  logic [SW-1:0] exp17;

  string_loader #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_byte      (wr_byte),
    .wr_last      (wr_last),
    .abort        (abort),
    .err_clr      (err_clr),
    .string_out   (string_out),
    .strlen_out   (strlen_out),
    .str_valid    (str_valid),
    .cmp_clear    (cmp_clear),
    .err_overflow (err_overflow),
    .busy         (busy),
    .state_dbg    (state_dbg)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    wr_valid = 1'b1;
    wr_byte  = b;
    wr_last  = last;
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  initial begin
    n_rst = 1'b0; wr_valid = 1'b0; wr_byte = 8'h00; wr_last = 1'b0;
    abort = 1'b0; err_clr = 1'b0;
    for (int k = 0; k < MAX_LEN; k++) exp17[8*k +: 8] = 8'h41 + 8'(k);

    step(); step();
    check("rst_string", string_out, '0);
    check("rst_strlen", SW'(strlen_out), '0);
    check("rst_valid", SW'(str_valid), '0);
    check("rst_cmpclr", SW'(cmp_clear), '0);
    check("rst_err", SW'(err_overflow), '0);
    check("rst_busy", SW'(busy), '0);
    check("rst_ready", SW'(wr_ready), SW'(1));
    n_rst = 1'b1;
    step();

    // "EVIL"
    send(8'h45, 0); send(8'h56, 0); send(8'h49, 0); send(8'h4C, 1);
    check("evil_T_ready", SW'(wr_ready), '0);
    check("evil_T_busy", SW'(busy), SW'(1));
    check("evil_T_string", string_out, '0);
    check("evil_T_cmpclr", SW'(cmp_clear), '0);
    step();
    check("evil_string", string_out, SW'(32'h4C495645));
    check("evil_strlen", SW'(strlen_out), SW'(3));
    check("evil_valid", SW'(str_valid), SW'(1));
    check("evil_cmpclr", SW'(cmp_clear), SW'(1));
    check("evil_ready", SW'(wr_ready), SW'(1));
    step();
    check("evil_cmpclr_off", SW'(cmp_clear), '0);

    // Single byte
    send(8'h2F, 1);
    step();
    check("one_string", string_out, SW'(8'h2F));
    check("one_strlen", SW'(strlen_out), '0);

    // Full-length string
    for (int k = 0; k < MAX_LEN; k++) send(8'h41 + 8'(k), k == MAX_LEN - 1);
    step();
    check("full_string", string_out, exp17);
    check("full_strlen", SW'(strlen_out), SW'(16));
    check("full_cmpclr", SW'(cmp_clear), SW'(1));

    // 18 bytes: overflow on the last one
    for (int k = 0; k < MAX_LEN + 1; k++) send(8'h61 + 8'(k), k == MAX_LEN);
    check("ovf_err", SW'(err_overflow), SW'(1));
    check("ovf_busy", SW'(busy), '0);
    check("ovf_cmpclr0", SW'(cmp_clear), '0);
    step();
    check("ovf_cmpclr1", SW'(cmp_clear), '0);
    check("ovf_string", string_out, exp17);
    check("ovf_strlen", SW'(strlen_out), SW'(16));
    pulse_err_clr();
    check("errclr", SW'(err_overflow), '0);

    // 20 bytes: passes through DRAIN
    for (int k = 0; k < MAX_LEN + 3; k++) send(8'h30 + 8'(k), k == MAX_LEN + 2);
    check("drain_err", SW'(err_overflow), SW'(1));
    step();
    check("drain_string", string_out, exp17);
    check("drain_cmpclr", SW'(cmp_clear), '0);
    pulse_err_clr();
    check("errclr2", SW'(err_overflow), '0);

    // "AB", then abort partway through "XYZZY"
    send(8'h41, 0); send(8'h42, 1);
    step();
    check("ab_string", string_out, SW'(16'h4241));
    send(8'h58, 0); send(8'h59, 0); send(8'h5A, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_busy", SW'(busy), '0);
    check("abort_string", string_out, SW'(16'h4241));
    check("abort_strlen", SW'(strlen_out), SW'(1));
    check("abort_err", SW'(err_overflow), '0);
    step();
    check("abort_cmpclr", SW'(cmp_clear), '0);

    // Reset mid-load
    send(8'h70, 0); send(8'h71, 0);
    n_rst = 1'b0;
    #1;
    check("mid_rst_string", string_out, '0);
    check("mid_rst_strlen", SW'(strlen_out), '0);
    check("mid_rst_valid", SW'(str_valid), '0);
    check("mid_rst_busy", SW'(busy), '0);
    step();
    n_rst = 1'b1;
    step();

    send(8'h51, 0); send(8'h52, 1);
    step();
    check("post_rst_string", string_out, SW'(16'h5251));
    check("post_rst_strlen", SW'(strlen_out), SW'(1));
    check("post_rst_valid", SW'(str_valid), SW'(1));

    // wr_valid held across two strings; COMMIT stalls the first byte of the second
    wr_valid = 1'b1; wr_byte = 8'hA1; wr_last = 1'b0;
    step();
    wr_byte = 8'hA2; wr_last = 1'b1;
    step();
    check("b2b_stall_ready", SW'(wr_ready), '0);
    wr_byte = 8'hB1; wr_last = 1'b0;
    step();
    check("b2b_first_string", string_out, SW'(16'hA2A1));
    check("b2b_first_cmpclr", SW'(cmp_clear), SW'(1));
    step();
    check("b2b_busy_load", SW'(busy), SW'(1));
    check("b2b_cmpclr_off", SW'(cmp_clear), '0);
    wr_byte = 8'hB2; wr_last = 1'b1;
    step();
    wr_valid = 1'b0; wr_last = 1'b0;
    step();
    check("b2b_second_string", string_out, SW'(16'hB2B1));
    check("b2b_second_strlen", SW'(strlen_out), SW'(1));
    check("b2b_second_cmpclr", SW'(cmp_clear), SW'(1));
    step();
    check("b2b_end_cmpclr", SW'(cmp_clear), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/string_loader.md
Name: string_loader

Overview:
- Host-side writer for the sniffer's string-match path.
- Accepts a corrupt-string byte stream from the Atom programming interface over a valid/ready handshake.
- Assembles the string in a shadow buffer, then commits it atomically to the string/strlen bus that feeds the string comparator.
- Pulses the comparator's clear on every commit so no match is reported against a half-old/half-new pattern.

Parameters:
- MAX_LEN, 17, maximum string length in bytes; matches the comparator pattern width.
- LEN_W, 5, width of strlen_out; must satisfy 2^LEN_W > MAX_LEN.

Ports:
- clk  in  1  clock
- n_rst  in  1  reset; asynchronous, active-low
- wr_valid  in  1  host presents wr_byte
- wr_ready  out  1  loader can accept a byte this cycle
- wr_byte  in  8  string character
- wr_last  in  1  qualifies wr_byte as the final character; requests commit
- abort  in  1  discard the in-progress string
- err_clr  in  1  clears sticky err_overflow
- string_out  out  8*MAX_LEN  active pattern; byte k at bits [8k+7:8k], byte 0 is the first character
- strlen_out  out  LEN_W  index of the last valid character (length-1)
- str_valid  out  1  a string has been committed since reset
- cmp_clear  out  1  one-cycle clear to the comparator
- err_overflow  out  1  sticky; a string longer than MAX_LEN was rejected
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE, byte count=0, shadow buffer zeroed.
  - string_out=0, strlen_out=0, str_valid=0, cmp_clear=0, err_overflow=0.
- A transfer occurs on a rising edge with wr_valid && wr_ready.
- wr_ready=1 in IDLE, LOAD and DRAIN; 0 in COMMIT.
- States:
  - IDLE:
    - Transfer stores wr_byte at shadow[0] and sets count=1.
    - Goes to COMMIT if wr_last, else LOAD.
  - LOAD, transfer with count<MAX_LEN:
    - Stores wr_byte at shadow[count] and increments count.
    - Goes to COMMIT if wr_last, else stays in LOAD.
  - LOAD, transfer with count==MAX_LEN (byte MAX_LEN+1):
    - Byte is discarded.
    - If wr_last: sets err_overflow and goes to IDLE.
    - Else goes to DRAIN.
  - DRAIN:
    - Accepts and discards bytes.
    - On transfer with wr_last: sets err_overflow and goes to IDLE.
    - Active string is unchanged.
  - COMMIT (exactly one cycle):
    - At the closing edge: string_out <= shadow, with bytes at index >= count forced to 0.
    - Same edge: strlen_out <= count-1, str_valid <= 1, cmp_clear <= 1, count <= 0, state <= IDLE.
- Latency and cmp_clear timing:
  - Final byte transferred at edge T.
  - New string_out/strlen_out visible after edge T+1.
  - cmp_clear is high from edge T+1 to T+2, then returns to 0.
  - cmp_clear never exceeds one cycle.
- string_out and strlen_out change only at a COMMIT edge; they are never partially updated.
- abort:
  - Has priority over any transfer in the same cycle.
  - In LOAD/DRAIN: count <= 0, state <= IDLE, no commit, no error.
  - In COMMIT: ignored; the commit completes.
  - In IDLE: no effect.
  - wr_ready is unaffected by abort.
- err_clr:
  - Clears err_overflow.
  - If an overflow sets and err_clr clears in the same cycle, set wins.
- wr_valid held during COMMIT is not a transfer; the byte is accepted in the following IDLE cycle.
- Back-to-back strings are allowed: the next first byte can transfer the cycle after COMMIT.
- Reset mid-load: all state is lost; str_valid=0; string_out=0.
- Count width is LEN_W; the MAX_LEN check prevents count wrap.

Test Plan:
- "EVIL" (0x45,0x56,0x49,0x4C), wr_last on 0x4C -> after T+1:
  - string_out bytes0..3=45,56,49,4C; bytes4..16=00.
  - strlen_out=3, str_valid=1, cmp_clear high exactly 1 cycle, wr_ready=0 for 1 cycle.
- Single byte 0x2F with wr_last from IDLE -> strlen_out=0, byte0=2F, rest 00.
- 17 bytes 0x41..0x51 -> strlen_out=16, byte16=0x51.
- Then 18 bytes ending wr_last:
  - err_overflow=1, string_out still 0x41..0x51, no cmp_clear pulse.
  - err_clr -> err_overflow=0.
- Load "AB", then abort after 3 of 5 bytes of "XYZZY" -> string_out stays "AB", strlen_out=1, busy=0 next cycle.
- Assert n_rst low mid-load of a second string -> all outputs 0.
- New 2-byte string after release -> strlen_out=1, str_valid=1.
- wr_valid held continuously across two 2-byte strings -> COMMIT stalls one cycle between them, no byte lost; second commit yields the second string and a second cmp_clear pulse.
